fx2_fifo_sched: RTL

- Scheduler that shares the FX2LP synchronous slave-FIFO bus between two requesters:
  - OUT stream: EP2 → FPGA (rx).
  - IN stream: FPGA → EP6 (tx).
- Sequences FIFOADR, SLOE, SLRD, SLWR and PKTEND, handles bus turnaround, and arbitrates round-robin with bounded bursts.
- Sits between the FX2 pin-level interface and the FPGA stream logic.

---
 rtl/fx2_fifo_sched.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fx2_fifo_sched.sv
// Shares the FX2LP synchronous slave-FIFO bus between the EP2 OUT stream (rx) and the EP6 IN stream (tx).
// Optional idle partial-packet flush is enabled by defining FX2_IDLE_PKTEND_EN.
//
// state      | meaning
// S_IDLE     | bus parked, arbitrate between rd_req and wr_req
// S_RD_SETUP | FIFOADR=EP2, SLOE low, one cycle before the first SLRD
// S_RD       | read burst, SLRD gated by flaga & rx_ready
// S_WR_SETUP | FIFOADR=EP6, FD driven, bus turnaround cycle
// S_WR       | write burst, SLWR gated by flagd & tx_valid
// S_PKTEND   | one-cycle PKTEND strobe to commit a short packet
module fx2_fifo_sched #(
  parameter int BURST_MAX   = 64,
  parameter int PKT_SIZE    = 512,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flaga,
  input  logic       flagd,
  input  logic [7:0] fdata_i,
  output logic [7:0] fdata_o,
  output logic       fdata_oe,
  output logic [1:0] faddr,
  output logic       sloe,
  output logic       slrd,
  output logic       slwr,
  output logic       pkt_end,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int PW = $clog2(PKT_SIZE);

  if ((PKT_SIZE < 2) || ((PKT_SIZE & (PKT_SIZE - 1)) != 0) || (BURST_MAX < 1) || (TIMEOUT_CYC < 1))
  begin : g_bad_param
    $error("fx2_fifo_sched: invalid parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SETUP, S_RD, S_WR_SETUP, S_WR, S_PKTEND
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          prio_wr_q, prio_wr_d;
  logic          sloe_q, fdata_oe_q, pkt_end_q, busy_q;
  logic [1:0]    faddr_q;

  logic rd_req, wr_req, rd_xfer, wr_xfer, burst_last, pkt_last;

`ifdef FX2_IDLE_PKTEND_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          flush_q, flush_d, flush_due;
  assign flush_due = (idle_cnt_q == TW'(TIMEOUT_CYC));
`endif

  assign rd_req     = flaga & rx_ready;
  assign wr_req     = flagd & tx_valid;
  assign rd_xfer    = (state_q == S_RD) & rd_req;
  assign wr_xfer    = (state_q == S_WR) & wr_req;
  assign burst_last = (burst_q == BW'(BURST_MAX - 1));
  assign pkt_last   = (pkt_cnt_q == PW'(PKT_SIZE - 1));

  // Strobes are decoded from registered state plus live flags so a flag
  // dropping in the strobe cycle suppresses that transfer.
  assign slrd     = ~rd_xfer;
  assign slwr     = ~wr_xfer;
  assign tx_ready = wr_xfer;
  assign rx_valid = (state_q == S_RD) & flaga;
  assign rx_data  = fdata_i;
  assign fdata_o  = (state_q == S_WR) ? tx_data : 8'h00;

  assign sloe     = sloe_q;
  assign fdata_oe = fdata_oe_q;
  assign faddr    = faddr_q;
  assign pkt_end  = pkt_end_q;
  assign busy     = busy_q;

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    pkt_cnt_d = pkt_cnt_q;
    prio_wr_d = prio_wr_q;
`ifdef FX2_IDLE_PKTEND_EN
    flush_d   = flush_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef FX2_IDLE_PKTEND_EN
        if (flush_due) begin
          state_d = S_WR_SETUP;
          flush_d = 1'b1;
        end else
`endif
        if (rd_req && (!wr_req || !prio_wr_q)) begin
          state_d   = S_RD_SETUP;
          prio_wr_d = 1'b1;
        end else if (wr_req) begin
          state_d   = S_WR_SETUP;
          prio_wr_d = 1'b0;
        end
      end
      S_RD_SETUP: state_d = S_RD;
      S_RD: begin
        if (!rd_req) begin
          state_d = S_IDLE;
        end else begin
          burst_d = burst_q + BW'(1);
          if (burst_last) state_d = S_IDLE;
        end
      end
      S_WR_SETUP: begin
`ifdef FX2_IDLE_PKTEND_EN
        state_d = flush_q ? S_PKTEND : S_WR;
`else
        state_d = S_WR;
`endif
      end
      S_WR: begin
        if (!wr_req) begin
          state_d = S_IDLE;
        end else begin
          burst_d   = burst_q + BW'(1);
          pkt_cnt_d = pkt_last ? '0 : pkt_cnt_q + PW'(1);
          // A last byte landing on the packet boundary is auto-committed by the FX2.
          if (tx_last)         state_d = pkt_last ? S_IDLE : S_PKTEND;
          else if (burst_last) state_d = S_IDLE;
        end
      end
      S_PKTEND: begin
        pkt_cnt_d = '0;
        state_d   = S_IDLE;
`ifdef FX2_IDLE_PKTEND_EN
        flush_d   = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_IDLE) && (state_q != S_IDLE)) burst_d = '0;
  end

`ifdef FX2_IDLE_PKTEND_EN
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (wr_xfer || (pkt_cnt_q == '0) || flush_q) idle_cnt_d = '0;
    else if (!flush_due)                         idle_cnt_d = idle_cnt_q + TW'(1);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      burst_q    <= '0;
      pkt_cnt_q  <= '0;
      prio_wr_q  <= 1'b0;
      sloe_q     <= 1'b1;
      fdata_oe_q <= 1'b0;
      faddr_q    <= 2'b00;
      pkt_end_q  <= 1'b1;
      busy_q     <= 1'b0;
`ifdef FX2_IDLE_PKTEND_EN
      idle_cnt_q <= '0;
      flush_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      pkt_cnt_q  <= pkt_cnt_d;
      prio_wr_q  <= prio_wr_d;
      sloe_q     <= !((state_d == S_RD_SETUP) || (state_d == S_RD));
      fdata_oe_q <= (state_d == S_WR_SETUP) || (state_d == S_WR) || (state_d == S_PKTEND);
      faddr_q    <= ((state_d == S_WR_SETUP) || (state_d == S_WR) || (state_d == S_PKTEND))
                    ? 2'b10 : 2'b00;
      pkt_end_q  <= (state_d != S_PKTEND);
      busy_q     <= (state_d != S_IDLE);
`ifdef FX2_IDLE_PKTEND_EN
      idle_cnt_q <= idle_cnt_d;
      flush_q    <= flush_d;
`endif
    end
  end

endmodule
